// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Merges NUM_CH busy-handshake requester ports onto one shared
//               memory port. Round-robin or fixed-priority arbitration, with
//               a bus timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_CH-1:0]    req_en_i,
    input  logic [NUM_CH-1:0]    req_wen_i,
    input  logic [NUM_CH*AW-1:0] req_addr_i,
    input  logic [NUM_CH*DW-1:0] req_din_i,
    output logic [NUM_CH-1:0]    req_done_o,
    output logic [NUM_CH-1:0]    req_busy_o,
    output logic [NUM_CH-1:0]    req_err_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 mem_en_o,
    output logic                 mem_wen_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_din_o,
    input  logic                 mem_busy_i,
    input  logic [DW-1:0]        mem_dout_i,
    output logic [NUM_CH-1:0]    grant_o
);

    localparam int              c_PW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_PW-1:0] c_LAST    = c_PW'(NUM_CH - 1);
    localparam logic [15:0]     c_TIMEOUT = 16'(TIMEOUT);
    localparam logic            c_WD_EN   = (TIMEOUT != 0);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [NUM_CH-1:0] r_grant;
    logic [NUM_CH-1:0] r_done;
    logic [NUM_CH-1:0] r_err;
    logic [c_PW-1:0]   r_ptr;
    logic [15:0]       r_cnt;
    logic              r_mem_wen;
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_din;
    logic [DW-1:0]     r_rdata;
    logic              w_mem_en;

    logic [NUM_CH-1:0] w_req;
    logic              w_arb;
    logic [c_PW-1:0]   w_sel;
    logic [c_PW-1:0]   w_ptr_next;
    logic [15:0]       w_cnt_next;
    logic              w_active;
    logic              w_timeout;
    logic              w_accept;
    logic              w_complete;

    // A channel whose done is pulsing is still holding its old request.
    assign w_req      = req_en_i & ~r_done;
    assign w_arb      = (r_state == c_IDLE) && (|w_req) && (r_done == '0);
    assign w_ptr_next = (w_sel == c_LAST) ? '0 : w_sel + c_PW'(1);

    assign w_active   = (r_state == c_ISSUE) || (r_state == c_WAIT);
    assign w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_timeout  = c_WD_EN && w_active && mem_busy_i && (w_cnt_next >= c_TIMEOUT);
    assign w_accept   = (r_state == c_ISSUE) && !mem_busy_i;
    assign w_complete = (r_state == c_WAIT) && !mem_busy_i;

    generate
        if (ARB_MODE == 1) begin : g_fixed
            always_comb begin
                w_sel = '0;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (w_req[i]) begin
                        w_sel = c_PW'(i);
                    end
                end
            end
        end else begin : g_rr
            logic w_found;
            always_comb begin
                w_sel   = '0;
                w_found = 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!w_found && w_req[(int'(r_ptr) + i) % NUM_CH]) begin
                        w_sel   = c_PW'((int'(r_ptr) + i) % NUM_CH);
                        w_found = 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_arb) begin
                    w_state_next = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_timeout) begin
                    w_state_next = c_IDLE;
                end else if (w_accept) begin
                    w_state_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (w_complete || w_timeout) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_mem_en = 1'b0;
        if (r_state == c_ISSUE) begin
            w_mem_en = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_grant    <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_mem_wen  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rdata    <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (w_arb) begin
                r_grant    <= NUM_CH'(1) << w_sel;
                r_ptr      <= w_ptr_next;
                r_cnt      <= '0;
                r_mem_wen  <= req_wen_i[w_sel];
                r_mem_addr <= req_addr_i[int'(w_sel)*AW +: AW];
                r_mem_din  <= req_din_i[int'(w_sel)*DW +: DW];
            end
            if (w_active && mem_busy_i) begin
                r_cnt <= w_cnt_next;
            end
            if (w_timeout) begin
                r_done  <= r_grant;
                r_err   <= r_grant;
                r_rdata <= '0;
                r_grant <= '0;
            end else if (w_complete) begin
                r_done  <= r_grant;
                r_rdata <= r_mem_wen ? '0 : mem_dout_i;
                r_grant <= '0;
            end
        end
    end

    assign req_done_o = r_done;
    assign req_busy_o = req_en_i & ~r_done;
    assign req_err_o  = r_err;
    assign rdata_o    = r_rdata;
    assign mem_en_o   = w_mem_en;
    assign mem_wen_o  = r_mem_wen;
    assign mem_addr_o = r_mem_addr;
    assign mem_din_o  = r_mem_din;
    assign grant_o    = r_grant;

endmodule
`default_nettype wire
